// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared encodings and gate-length helper for the frequency meter
package freq_meter_pkg;

    typedef enum logic [1:0] {
        RANGE_1S    = 2'd0,
        RANGE_100MS = 2'd1,
        RANGE_10MS  = 2'd2,
        RANGE_1MS   = 2'd3
    } range_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } state_e;

    // Only ever evaluated into localparams, so the divides fold to constants.
    function automatic int unsigned gate_len(input int unsigned clk_hz, input range_e rng);
        case (rng)
            RANGE_1S:    return clk_hz;
            RANGE_100MS: return clk_hz / 10;
            RANGE_10MS:  return clk_hz / 100;
            default:     return clk_hz / 1000;
        endcase
    endfunction

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop synchronizer with rising-edge pulse output
module edge_sync (
    input  logic clk_50MHz,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge counter scaled to Hz with one-cycle result strobe
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                 clk_50MHz,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           range_sel,
    input  logic                 sig_in,
    output logic [CNT_W+10-1:0]  freq_hz,
    output logic                 freq_valid,
    output logic                 ovf,
    output logic                 busy
);

    localparam int unsigned OUT_W   = CNT_W + 10;
    localparam int unsigned G_1S    = gate_len(CLK_HZ, RANGE_1S);
    localparam int unsigned G_100MS = gate_len(CLK_HZ, RANGE_100MS);
    localparam int unsigned G_10MS  = gate_len(CLK_HZ, RANGE_10MS);
    localparam int unsigned G_1MS   = gate_len(CLK_HZ, RANGE_1MS);
    localparam int unsigned GATE_W  = $clog2(G_1S + 1);
    localparam logic [CNT_W-1:0] EDGE_MAX = '1;

    state_e             state_q, state_d;
    range_e             range_q, range_d;
    logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [OUT_W-1:0]   freq_q, freq_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;

    logic               rise;
    logic [GATE_W-1:0]  gate_last;
    logic [CNT_W-1:0]   edge_inc;
    logic [OUT_W-1:0]   e_ext;
    logic [OUT_W-1:0]   scaled;
    range_e             range_in;

    edge_sync u_edge_sync (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .d         (sig_in),
        .rise      (rise)
    );

    assign range_in = range_e'(range_sel);
    assign edge_inc = (edge_cnt_q == EDGE_MAX) ? edge_cnt_q : edge_cnt_q + 1'b1;
    assign e_ext    = OUT_W'(edge_cnt_q);

    always_comb begin
        case (range_q)
            RANGE_1S:    gate_last = GATE_W'(G_1S - 1);
            RANGE_100MS: gate_last = GATE_W'(G_100MS - 1);
            RANGE_10MS:  gate_last = GATE_W'(G_10MS - 1);
            default:     gate_last = GATE_W'(G_1MS - 1);
        endcase
    end

    // Shift-add scaling; the x1000 term is 1024 - 16 - 8.
    always_comb begin
        case (range_q)
            RANGE_1S:    scaled = e_ext;
            RANGE_100MS: scaled = (e_ext << 3) + (e_ext << 1);
            RANGE_10MS:  scaled = (e_ext << 6) + (e_ext << 5) + (e_ext << 2);
            default:     scaled = (e_ext << 10) - (e_ext << 4) - (e_ext << 3);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        range_d    = range_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        freq_d     = freq_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;

        case (state_q)
            IDLE: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                if (en) begin
                    state_d = GATE;
                    range_d = range_in;
                end
            end
            GATE: begin
                if (!en) begin
                    state_d    = IDLE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                end else if (range_in != range_q) begin
                    // The cycle that sees the new range is the first cycle of the new window.
                    range_d    = range_in;
                    gate_cnt_d = GATE_W'(1);
                    edge_cnt_d = rise ? CNT_W'(1) : '0;
                end else begin
                    gate_cnt_d = gate_cnt_q + 1'b1;
                    if (rise) begin
                        edge_cnt_d = edge_inc;
                    end
                    if (gate_cnt_q == gate_last) begin
                        state_d = LATCH;
                    end
                end
            end
            LATCH: begin
                freq_d     = scaled;
                ovf_d      = (edge_cnt_q == EDGE_MAX);
                valid_d    = 1'b1;
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                if (en) begin
                    state_d = GATE;
                    range_d = range_in;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                gate_cnt_d = '0;
                edge_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            range_q    <= RANGE_1S;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            freq_q     <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            range_q    <= range_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            freq_q     <= freq_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    assign freq_hz    = freq_q;
    assign freq_valid = valid_q;
    assign ovf        = ovf_q;
    assign busy       = (state_q == GATE);

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed bench for freq_meter at CLK_HZ = 8000, CNT_W = 32 and 8
module tb_freq_meter;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  range_sel;
    logic        sig_in;
    logic        gen_sig;
    logic        sig_level;
    int          sig_period;
    int          ph;

    logic [41:0] freq_a;
    logic        valid_a, ovf_a, busy_a;
    logic [17:0] freq_b;
    logic        valid_b, ovf_b, busy_b;

    int tests_run;
    int tests_failed;

    freq_meter #(.CLK_HZ(8000), .CNT_W(32)) dut (
        .clk_50MHz (clk), .rst (rst), .en (en), .range_sel (range_sel), .sig_in (sig_in),
        .freq_hz (freq_a), .freq_valid (valid_a), .ovf (ovf_a), .busy (busy_a)
    );

    freq_meter #(.CLK_HZ(8000), .CNT_W(8)) dut8 (
        .clk_50MHz (clk), .rst (rst), .en (en), .range_sel (range_sel), .sig_in (sig_in),
        .freq_hz (freq_b), .freq_valid (valid_b), .ovf (ovf_b), .busy (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sig_in = (sig_period == 0) ? sig_level : gen_sig;

    // Square wave of sig_period clocks, changing 2 time units after each rising edge.
    initial begin
        gen_sig = 1'b0;
        ph = 0;
        forever begin
            @(posedge clk);
            #2;
            if (sig_period > 0) begin
                ph = (ph + 1 >= sig_period) ? 0 : ph + 1;
                gen_sig = (ph < sig_period / 2);
            end
        end
    end

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!valid_a && n <= limit);
    endtask

    task automatic start_window(input logic [1:0] r, input int period);
        en = 1'b0;
        sig_period = period;
        repeat (4) @(negedge clk);
        range_sel = r;
        en = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en = 1'b0;
        range_sel = 2'd0;
        sig_period = 0;
        sig_level = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (freq_a !== 42'd0) begin tests_failed++; $display("FAIL reset_freq_a: got %0d expected 0", freq_a); end
        tests_run++; if (freq_b !== 18'd0) begin tests_failed++; $display("FAIL reset_freq_b: got %0d expected 0", freq_b); end
        tests_run++; if ({valid_a, valid_b} !== 2'b00) begin tests_failed++; $display("FAIL reset_valid: got %b expected 00", {valid_a, valid_b}); end
        tests_run++; if ({ovf_a, ovf_b} !== 2'b00) begin tests_failed++; $display("FAIL reset_ovf: got %b expected 00", {ovf_a, ovf_b}); end
        tests_run++; if ({busy_a, busy_b} !== 2'b00) begin tests_failed++; $display("FAIL reset_busy: got %b expected 00", {busy_a, busy_b}); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_range0;
        int n;
        start_window(2'd0, 16);
        wait_valid(9000, n);
        tests_run++; if (n != 8001) begin tests_failed++; $display("FAIL r0_latency: got %0d expected 8001", n); end
        tests_run++; if (freq_a < 499 || freq_a > 501) begin tests_failed++; $display("FAIL r0_freq: got %0d expected 499..501", freq_a); end
        tests_run++; if (ovf_a !== 1'b0) begin tests_failed++; $display("FAIL r0_ovf: got %b expected 0", ovf_a); end
        @(negedge clk);
        tests_run++; if (valid_a !== 1'b0) begin tests_failed++; $display("FAIL r0_valid_width: got %b expected 0", valid_a); end
    endtask

    task automatic test_range1;
        int n;
        start_window(2'd1, 80);
        wait_valid(1000, n);
        tests_run++; if (n != 801) begin tests_failed++; $display("FAIL r1_latency: got %0d expected 801", n); end
        tests_run++; if (freq_a < 90 || freq_a > 110) begin tests_failed++; $display("FAIL r1_freq: got %0d expected 90..110", freq_a); end
        for (int w = 0; w < 2; w++) begin
            wait_valid(1000, n);
            tests_run++; if (n != 801) begin tests_failed++; $display("FAIL r1_period_%0d: got %0d expected 801", w, n); end
            tests_run++; if (freq_a < 90 || freq_a > 110) begin tests_failed++; $display("FAIL r1_freq_%0d: got %0d expected 90..110", w, freq_a); end
        end
    endtask

    task automatic test_range3;
        int n;
        start_window(2'd3, 4);
        for (int w = 0; w < 3; w++) begin
            wait_valid(50, n);
            tests_run++; if (n != 9) begin tests_failed++; $display("FAIL r3_period_%0d: got %0d expected 9", w, n); end
            tests_run++; if (freq_a < 1000 || freq_a > 3000) begin tests_failed++; $display("FAIL r3_freq_%0d: got %0d expected 1000..3000", w, freq_a); end
        end
    endtask

    task automatic test_final_cycle_edge;
        int n;
        sig_level = 1'b0;
        start_window(2'd3, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        sig_level = 1'b1;
        wait_valid(50, n);
        tests_run++; if (n != 4) begin tests_failed++; $display("FAIL edge_final_latency: got %0d expected 4", n); end
        tests_run++; if (freq_a !== 42'd1000) begin tests_failed++; $display("FAIL edge_final_freq: got %0d expected 1000", freq_a); end
        en = 1'b0;
    endtask

    task automatic test_abort;
        int saw;
        saw = 0;
        start_window(2'd0, 16);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (valid_a) saw++;
        end
        tests_run++; if (busy_a !== 1'b1) begin tests_failed++; $display("FAIL abort_busy_before: got %b expected 1", busy_a); end
        en = 1'b0;
        @(negedge clk);
        tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL abort_busy_after: got %b expected 0", busy_a); end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valid_a) saw++;
        end
        tests_run++; if (saw != 0) begin tests_failed++; $display("FAIL abort_no_valid: got %0d pulses expected 0", saw); end
        tests_run++; if (freq_a !== 42'd1000) begin tests_failed++; $display("FAIL abort_freq_kept: got %0d expected 1000", freq_a); end
        tests_run++; if (freq_b !== 18'd1000) begin tests_failed++; $display("FAIL abort_freq8_kept: got %0d expected 1000", freq_b); end
    endtask

    task automatic test_range_change;
        int n;
        start_window(2'd0, 16);
        repeat (100) @(negedge clk);
        range_sel = 2'd2;
        @(posedge clk);
        wait_valid(200, n);
        tests_run++; if (n != 80) begin tests_failed++; $display("FAIL restart_latency: got %0d expected 80", n); end
        tests_run++; if (freq_a < 400 || freq_a > 600) begin tests_failed++; $display("FAIL restart_freq: got %0d expected 400..600", freq_a); end
        en = 1'b0;
    endtask

    task automatic test_reset_mid_gate;
        int n;
        start_window(2'd0, 16);
        repeat (1000) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        tests_run++; if (freq_a !== 42'd0) begin tests_failed++; $display("FAIL rstmid_freq: got %0d expected 0", freq_a); end
        tests_run++; if ({valid_a, ovf_a, busy_a} !== 3'b000) begin tests_failed++; $display("FAIL rstmid_flags: got %b expected 000", {valid_a, ovf_a, busy_a}); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        wait_valid(9000, n);
        tests_run++; if (n != 8001) begin tests_failed++; $display("FAIL rstmid_latency: got %0d expected 8001", n); end
        tests_run++; if (freq_a < 499 || freq_a > 501) begin tests_failed++; $display("FAIL rstmid_freq_after: got %0d expected 499..501", freq_a); end
    endtask

    task automatic test_overflow;
        int n;
        start_window(2'd0, 4);
        wait_valid(9000, n);
        tests_run++; if (n != 8001) begin tests_failed++; $display("FAIL ovf_latency: got %0d expected 8001", n); end
        tests_run++; if (freq_b !== 18'd255) begin tests_failed++; $display("FAIL ovf_freq8: got %0d expected 255", freq_b); end
        tests_run++; if (ovf_b !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag8: got %b expected 1", ovf_b); end
        tests_run++; if (freq_a < 1999 || freq_a > 2001 || ovf_a !== 1'b0) begin tests_failed++; $display("FAIL ovf_wide: got %0d/%b expected 1999..2001/0", freq_a, ovf_a); end
        sig_level = 1'b0;
        start_window(2'd0, 0);
        wait_valid(9000, n);
        tests_run++; if (n != 8001) begin tests_failed++; $display("FAIL quiet_latency: got %0d expected 8001", n); end
        tests_run++; if (freq_b !== 18'd0 || ovf_b !== 1'b0) begin tests_failed++; $display("FAIL quiet_freq8: got %0d/%b expected 0/0", freq_b, ovf_b); end
        tests_run++; if (freq_a !== 42'd0) begin tests_failed++; $display("FAIL quiet_freq: got %0d expected 0", freq_a); end
        en = 1'b0;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_range0();
        test_range1();
        test_range3();
        test_final_cycle_edge();
        test_abort();
        test_range_change();
        test_reset_mid_gate();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
